// File: rtl/load_store_unit.sv
// Load/store unit: one memory access at a time, with alignment checking,
// byte-lane steering for stores, and sign/zero formatting for loads.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mem_read,
    input  logic [2:0]  mem_write,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [63:0] bus_rdata,
    output logic [63:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t      state;
    logic        op_load;
    logic [2:0]  op_code;
    logic [2:0]  op_off;

    logic        sel_present;
    logic        sel_load;
    logic [2:0]  sel_code;
    logic [1:0]  sel_lg;

    // log2 of the access size; the low two code bits encode B/H/W, 00 means D
    function automatic logic [1:0] size_lg(input logic [2:0] code);
        case (code[1:0])
            2'd1:    return 2'd0;
            2'd2:    return 2'd1;
            2'd3:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] lg, input logic [2:0] off);
        case (lg)
            2'd0:    return 1'b1;
            2'd1:    return off[0] == 1'b0;
            2'd2:    return off[1:0] == 2'b00;
            default: return off == 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] strb_of(input logic [1:0] lg, input logic [2:0] off);
        case (lg)
            2'd0:    return 8'h01 << off;
            2'd1:    return 8'h03 << off;
            2'd2:    return 8'h0F << off;
            default: return 8'hFF;
        endcase
    endfunction

    // Extract the addressed lane and extend; code[2] marks the unsigned loads (LD has lg=3)
    function automatic logic [63:0] format_load(input logic [2:0] code, input logic [2:0] off,
                                                input logic [63:0] rdata);
        logic [63:0] s;
        logic        sx;
        s  = rdata >> {off, 3'b000};
        sx = ~code[2];
        case (size_lg(code))
            2'd0:    return {{56{sx & s[7]}},  s[7:0]};
            2'd1:    return {{48{sx & s[15]}}, s[15:0]};
            2'd2:    return {{32{sx & s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    assign sel_load    = (mem_read != 3'b000);
    assign sel_present = sel_load || (mem_write != 3'b000);
    assign sel_code    = sel_load ? mem_read : mem_write;
    assign sel_lg      = size_lg(sel_code);

    assign stall = !rst && (((state == IDLE) && sel_present) || (state == REQ));

    // Access sequencer with registered bus and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_load    <= 1'b0;
            op_code    <= 3'b000;
            op_off     <= 3'b000;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 64'd0;
            bus_wdata  <= 64'd0;
            bus_wstrb  <= 8'd0;
            load_data  <= 64'd0;
            done       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_present) begin
                        op_load <= sel_load;
                        op_code <= sel_code;
                        op_off  <= addr[2:0];
                        if (is_aligned(sel_lg, addr[2:0])) begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= !sel_load;
                            bus_addr  <= {addr[63:3], 3'b000};
                            bus_wdata <= sel_load ? 64'd0 : (store_data << {addr[2:0], 3'b000});
                            bus_wstrb <= sel_load ? 8'd0 : strb_of(sel_lg, addr[2:0]);
                        end else begin
                            state      <= ERR;
                            misaligned <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        state     <= DONE;
                        bus_req   <= 1'b0;
                        done      <= 1'b1;
                        load_data <= op_load ? format_load(op_code, op_off, bus_rdata) : 64'd0;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases plus random accesses
// checked against a byte-level behavioural model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mem_read;
    logic [2:0]  mem_write;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_ready;
    logic [63:0] bus_rdata;
    logic [63:0] load_data;
    logic        done;
    logic        stall;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_ld = 64'd0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .store_data(store_data), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .load_data(load_data),
        .done(done), .stall(stall), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    function automatic int bytes_of(input logic [2:0] code);
        case (code)
            3'd1, 3'd5: return 1;
            3'd2, 3'd6: return 2;
            3'd3, 3'd7: return 4;
            default:    return 8;
        endcase
    endfunction

    task automatic scramble_inputs();
        mem_read   = 3'($urandom);
        mem_write  = 3'($urandom);
        addr       = {$urandom, $urandom};
        store_data = {$urandom, $urandom};
    endtask

    task automatic clear_inputs();
        mem_read = 3'd0; mem_write = 3'd0; addr = 64'd0; store_data = 64'd0;
    endtask

    // Present one access at the current cycle and follow it to completion
    task automatic run_access(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] ad,
                              input logic [63:0] sd, input logic [63:0] rdat, input int waits);
        logic        is_load;
        logic        sgn;
        logic [2:0]  code;
        int          size;
        int          a;
        logic [63:0] e_wdata, e_addr, v, mask;
        logic [7:0]  e_wstrb;
        is_load = (rd != 0);
        code    = is_load ? rd : wr;
        size    = bytes_of(code);
        a       = int'(ad % 8);
        e_addr  = ad - 64'(a);
        e_wdata = is_load ? 64'd0 : (sd << (8 * a));
        e_wstrb = is_load ? 8'd0 : 8'(((1 << size) - 1) << a);
        v       = rdat >> (8 * a);
        sgn     = is_load && (code <= 3'd3);
        if (size < 8) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            v    = v & mask;
            if (sgn && v[8 * size - 1]) v = v | ~mask;
        end

        mem_read = rd; mem_write = wr; addr = ad; store_data = sd;
        bus_ready = 1'b0;
        #1;
        if (rd == 0 && wr == 0) begin
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %0b want 0", stall); end
            @(posedge clk); #1;
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %0b want 0", bus_req); end
            return;
        end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sample_stall: got %0b want 1", stall); end
        @(posedge clk); #1;
        scramble_inputs();
        #1;
        if ((ad % 64'(size)) != 0) begin
            checks++; if ({misaligned, bus_req, stall, done} !== 4'b1000) begin
                errors++; $display("FAIL err_cycle: got mis/req/stall/done=%b want 1000", {misaligned, bus_req, stall, done}); end
            @(posedge clk); #1;
            checks++; if ({misaligned, bus_req, load_data} !== {2'b00, exp_ld}) begin
                errors++; $display("FAIL after_err: got mis=%0b req=%0b ld=%h want 0 0 %h", misaligned, bus_req, load_data, exp_ld); end
            clear_inputs();
            return;
        end
        for (int k = 0; k <= waits; k++) begin
            checks++; if ({bus_req, stall, done, bus_we} !== {3'b110, !is_load}) begin
                errors++; $display("FAIL req_ctl: got req/stall/done/we=%b want 110%0b", {bus_req, stall, done, bus_we}, !is_load); end
            checks++; if ({bus_addr, bus_wdata, bus_wstrb} !== {e_addr, e_wdata, e_wstrb}) begin
                errors++; $display("FAIL req_bus: got addr=%h wdata=%h wstrb=%h want %h %h %h",
                                   bus_addr, bus_wdata, bus_wstrb, e_addr, e_wdata, e_wstrb); end
            bus_ready = (k == waits);
            bus_rdata = (k == waits) ? rdat : {$urandom, $urandom};
            @(posedge clk); #1;
        end
        bus_ready = 1'b0;
        bus_rdata = {$urandom, $urandom};
        exp_ld = is_load ? v : 64'd0;
        #1;
        checks++; if ({done, bus_req, stall} !== 3'b100) begin
            errors++; $display("FAIL done_cycle: got done/req/stall=%b want 100", {done, bus_req, stall}); end
        checks++; if (load_data !== exp_ld) begin
            errors++; $display("FAIL load_data: got %h want %h", load_data, exp_ld); end
        @(posedge clk); #1;
        checks++; if ({done, load_data} !== {1'b0, exp_ld}) begin
            errors++; $display("FAIL after_done: got done=%0b ld=%h want 0 %h", done, load_data, exp_ld); end
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_ready = 1'b1; bus_rdata = 64'd0;
        clear_inputs();
        mem_read = 3'b011;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({bus_req, bus_we, bus_wstrb, done, misaligned, stall} !== 13'd0) begin
            errors++; $display("FAIL reset_ctl: got %b want 0", {bus_req, bus_we, bus_wstrb, done, misaligned, stall}); end
        checks++; if ({bus_addr, bus_wdata, load_data} !== 192'd0) begin
            errors++; $display("FAIL reset_data: got %h %h %h want 0", bus_addr, bus_wdata, load_data); end
        bus_ready = 1'b0;
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_byte_loads();
        run_access(3'b001, 3'b000, 64'h1003, 64'd0, 64'h00000000_8F000000, 0);
        checks++; if (load_data !== 64'hFFFFFFFF_FFFFFF8F) begin
            errors++; $display("FAIL lb_value: got %h want ffffffffffffff8f", load_data); end
        run_access(3'b101, 3'b000, 64'h1003, 64'd0, 64'h00000000_8F000000, 0);
        checks++; if (load_data !== 64'h00000000_0000008F) begin
            errors++; $display("FAIL lbu_value: got %h want 000000000000008f", load_data); end
    endtask

    task automatic test_store_half();
        run_access(3'b000, 3'b010, 64'h2006, 64'h1234, 64'hDEAD, 0);
        checks++; if (load_data !== 64'd0) begin
            errors++; $display("FAIL sh_load_data: got %h want 0", load_data); end
    endtask

    task automatic test_misaligned();
        run_access(3'b011, 3'b000, 64'h1002, 64'd0, 64'd0, 0);
    endtask

    task automatic test_wait_states();
        run_access(3'b100, 3'b000, 64'h3000, 64'd0, 64'hA5A5_0123_4567_89AB, 3);
        checks++; if (load_data !== 64'hA5A5_0123_4567_89AB) begin
            errors++; $display("FAIL ld_value: got %h want a5a50123456789ab", load_data); end
    endtask

    task automatic test_reset_mid_req();
        mem_read = 3'b100; addr = 64'h3008; bus_ready = 1'b0;
        @(posedge clk); #1;
        clear_inputs();
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %0b want 1", bus_req); end
        @(posedge clk); #2;
        rst = 1'b1;
        bus_ready = 1'b1;
        #1;
        checks++; if ({bus_req, bus_we, bus_wstrb, done, misaligned, stall} !== 13'd0 ||
                      {bus_addr, bus_wdata, load_data} !== 192'd0) begin
            errors++; $display("FAIL mid_reset: got req=%0b addr=%h ld=%h done=%0b want all 0", bus_req, bus_addr, load_data, done); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus_ready = 1'b0;
        exp_ld = 64'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if ({done, bus_req} !== 2'b00) begin
                errors++; $display("FAIL post_reset_%0d: got done/req=%b want 00", k, {done, bus_req}); end
        end
        run_access(3'b000, 3'b100, 64'h40, 64'h0102_0304_0506_0708, 64'd0, 1);
    endtask

    task automatic test_load_wins();
        run_access(3'b011, 3'b011, 64'h10, 64'hFFFF_FFFF, 64'h1111_2222_8000_0001, 0);
        checks++; if (load_data !== 64'hFFFFFFFF_80000001) begin
            errors++; $display("FAIL load_wins: got %h want ffffffff80000001", load_data); end
    endtask

    task automatic test_random();
        logic [2:0]  rd, wr;
        logic [63:0] ad;
        for (int i = 0; i < 60; i++) begin
            rd = 3'd0; wr = 3'd0;
            case ($urandom_range(0, 3))
                0: rd = 3'($urandom_range(1, 7));
                1: wr = 3'($urandom_range(1, 4));
                2: begin rd = 3'($urandom_range(1, 7)); wr = 3'($urandom_range(1, 4)); end
                default: ;
            endcase
            ad = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) ad[2:0] = 3'd0;
            run_access(rd, wr, ad, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2));
        end
    endtask

    initial begin
        bus_ready = 1'b0;
        bus_rdata = 64'd0;
        test_reset();
        test_byte_loads();
        test_store_half();
        test_misaligned();
        test_wait_states();
        test_reset_mid_req();
        test_load_wins();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
